pot_key_scan: RTL
=================

POT_KEY_SCAN -- requirements
Module: pot_key_scan

Interface
REQ-001 SHALL provide parameter NUM_POTS, default 8, number of pot channels (1..8).
REQ-002 SHALL provide parameter POT_MAX, default 228, terminal pot count (fits 8 bits).
REQ-003 SHALL provide parameter SLOW_DIV, default 114, o2 cycles per slow pot tick.
REQ-004 SHALL provide parameter KEY_DIV, default 114, o2 cycles per keyboard scan step.
REQ-005 SHALL have port o2  input  1  system clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port pot_scan  input  NUM_POTS  per-channel comparator; 1 = pot threshold reached.
REQ-008 SHALL have port kr1_L  input  1  key-row return, low = key at current scan index pressed.
REQ-009 SHALL have port kr2_L  input  1  modifier (shift) return, low = modifier pressed.
REQ-010 SHALL have port addr_bus  input  4  register address.
REQ-011 SHALL have port wr_en  input  1  write strobe qualifying addr_bus.
REQ-012 SHALL have port fast_mode  input  1  1 = pot counter ticks every o2 cycle.
REQ-013 SHALL have port key_scan_L  output  6  bitwise inverse of keyboard scan index.
REQ-014 SHALL have port data_out  output  8  read data for addr_bus.
REQ-015 SHALL have port kbd_irq  output  1  one-cycle pulse on accepted key.

Function
REQ-016 Pot FSM SHALL have states IDLE and SCAN; wr_en with addr_bus=4'hB (POTGO) SHALL enter SCAN from any state, clear bin_ctr_pot to 0, clear compare_latch to all 0.
REQ-017 Pot tick SHALL be every o2 cycle when fast_mode=1, else every SLOW_DIV-th cycle (divider cleared by POTGO); bin_ctr_pot SHALL increment by 1 per tick in SCAN, 8-bit, never wraps.
REQ-018 On a tick in SCAN, each channel i with pot_scan[i]=1 and compare_latch[i]=0 SHALL load POTi <= current bin_ctr_pot (pre-increment value) and set compare_latch[i].
REQ-019 On the tick where bin_ctr_pot = POT_MAX, every unlatched channel SHALL load POTi <= POT_MAX, all latches set, FSM -> IDLE; a capture on that same tick also loads POT_MAX.
REQ-020 POTi SHALL hold value between scans; POTGO SHALL not clear POTi.
REQ-021 ALLPOT bit i SHALL read 1 while channel i is unlatched in SCAN, else 0; bits >= NUM_POTS read 0.
REQ-022 Keyboard scan index SHALL increment mod 64 every KEY_DIV cycles, continuously after reset.
REQ-023 Key FSM SHALL have states K_IDLE, K_CHECK, K_HELD, evaluated only on scan-step cycles at the current index.
REQ-024 K_IDLE: kr1_L=0 -> candidate <= index, K_CHECK.
REQ-025 K_CHECK, index=candidate: kr1_L=0 -> KBCODE <= {1'b0, shift, candidate}, kbd_irq pulse, K_HELD; kr1_L=1 -> K_IDLE; other indices ignored.
REQ-026 shift SHALL be set when kr2_L=0 on any step in the current 64-step pass and sampled into KBCODE[6] at acceptance; shift cleared at index 0.
REQ-027 K_HELD, index=candidate: kr1_L=1 -> K_IDLE; else stay; other keys ignored while held.
REQ-028 data_out SHALL be combinational: 4'h0-4'h7 POTn (0 for n >= NUM_POTS), 4'h8 ALLPOT, 4'h9 KBCODE, 4'hF SKSTAT = {5'b11111, ~key_held, 2'b11}, others 8'h00.
REQ-029 Writes to addresses other than 4'hB SHALL have no effect.

Reset
REQ-030 rst SHALL force: pot FSM IDLE, bin_ctr_pot=0, compare_latch=all 1, POTn=0, scan index 0 (key_scan_L=6'h3F), key FSM K_IDLE, KBCODE=0, shift=0, kbd_irq=0, dividers 0.
REQ-031 rst SHALL take priority over POTGO and scan events in the same cycle; rst mid-scan SHALL abandon scan with ALLPOT=0.

Verification
REQ-032 fast_mode=1, POTGO, pot_scan[3] rises 5 ticks later -> POT3=5, ALLPOT=8'hF7 after capture.
REQ-033 fast_mode=1, POTGO, no pot_scan -> after POT_MAX+1 ticks all POTn=228, ALLPOT=0, FSM IDLE.
REQ-034 POTGO issued mid-scan at count 40 -> bin_ctr_pot restarts at 0, ALLPOT=8'hFF, prior POTn retained until recaptured.
REQ-035 KEY_DIV=2, kr1_L=0 only at index 12 for two passes with kr2_L=0 -> KBCODE=8'h4C, one kbd_irq pulse, SKSTAT bit2=0.
REQ-036 kr1_L low at index 12 for one pass only -> no kbd_irq, KBCODE unchanged; release in K_HELD -> SKSTAT bit2=1.
REQ-037 rst asserted during SCAN and K_HELD -> next cycle all reset values of REQ-030, data_out at 4'h8 = 8'h00.

Source files
------------

// File: rtl/pot_key_scan.sv
// rtl/pot_key_scan.sv - pot counter/capture block and keyboard scanner with register readback
//
// Ports:
//   o2          in   system clock, all state on rising edge
//   rst         in   synchronous active-high reset
//   pot_scan    in   per-channel comparator, 1 = pot threshold reached
//   kr1_L       in   key-row return, low = key at current scan index pressed
//   kr2_L       in   modifier (shift) return, low = modifier pressed
//   addr_bus    in   register address (read mux and write decode)
//   wr_en       in   write strobe qualifying addr_bus (only 4'hB = POTGO acts)
//   fast_mode   in   1 = pot counter ticks every o2 cycle
//   key_scan_L  out  bitwise inverse of keyboard scan index
//   data_out    out  combinational read data for addr_bus
//   kbd_irq     out  one-cycle pulse on accepted key
module pot_key_scan #(
  parameter int NUM_POTS = 8,
  parameter int POT_MAX  = 228,
  parameter int SLOW_DIV = 114,
  parameter int KEY_DIV  = 114
) (
  input  logic                o2,
  input  logic                rst,
  input  logic [NUM_POTS-1:0] pot_scan,
  input  logic                kr1_L,
  input  logic                kr2_L,
  input  logic [3:0]          addr_bus,
  input  logic                wr_en,
  input  logic                fast_mode,
  output logic [5:0]          key_scan_L,
  output logic [7:0]          data_out,
  output logic                kbd_irq
);

  localparam int SDW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam int KDW = (KEY_DIV > 1) ? $clog2(KEY_DIV) : 1;

  typedef enum logic {
    IDLE,
    SCAN
  } pot_state_t;

  typedef enum logic [1:0] {
    K_IDLE,
    K_CHECK,
    K_HELD
  } key_state_t;

  // ---------------------------------------------------------------- pot side
  pot_state_t          pot_state_q, pot_state_d;
  logic [7:0]          ctr_q, ctr_d;
  logic [NUM_POTS-1:0] latch_q, latch_d;
  logic [7:0]          pot_q [NUM_POTS];
  logic [7:0]          pot_d [NUM_POTS];
  logic [SDW-1:0]      sdiv_q, sdiv_d;

  logic potgo;
  logic sdiv_tick;
  logic pot_tick;
  logic at_max;

  assign potgo     = wr_en && (addr_bus == 4'hB);
  assign sdiv_tick = (sdiv_q == SDW'(SLOW_DIV - 1));
  assign pot_tick  = fast_mode || sdiv_tick;
  assign at_max    = (ctr_q == 8'(POT_MAX));

  always_comb begin
    pot_state_d = pot_state_q;
    ctr_d       = ctr_q;
    latch_d     = latch_q;
    pot_d       = pot_q;
    sdiv_d      = sdiv_tick ? '0 : sdiv_q + SDW'(1);

    if (potgo) begin
      // POTGO restarts from any state; pot values are deliberately kept
      pot_state_d = SCAN;
      ctr_d       = 8'd0;
      latch_d     = '0;
      sdiv_d      = '0;
    end else if (pot_state_q == SCAN && pot_tick) begin
      // Capture uses the pre-increment count; on the terminal tick every
      // still-open channel is forced, which also yields POT_MAX for a
      // channel whose comparator fires on that same tick.
      for (int i = 0; i < NUM_POTS; i++) begin
        if (!latch_q[i] && (pot_scan[i] || at_max)) begin
          pot_d[i]   = ctr_q;
          latch_d[i] = 1'b1;
        end
      end
      if (at_max) begin
        pot_state_d = IDLE;
      end else begin
        ctr_d = ctr_q + 8'd1;
      end
    end
  end

  always_ff @(posedge o2) begin
    if (rst) begin
      pot_state_q <= IDLE;
      ctr_q       <= 8'd0;
      latch_q     <= '1;
      sdiv_q      <= '0;
      for (int i = 0; i < NUM_POTS; i++) begin
        pot_q[i] <= 8'd0;
      end
    end else begin
      pot_state_q <= pot_state_d;
      ctr_q       <= ctr_d;
      latch_q     <= latch_d;
      sdiv_q      <= sdiv_d;
      for (int i = 0; i < NUM_POTS; i++) begin
        pot_q[i] <= pot_d[i];
      end
    end
  end

  // ----------------------------------------------------------- keyboard side
  key_state_t     key_state_q, key_state_d;
  logic [5:0]     idx_q, idx_d;
  logic [5:0]     cand_q, cand_d;
  logic [7:0]     kbcode_q, kbcode_d;
  logic           shift_q, shift_d;
  logic           irq_q, irq_d;
  logic [KDW-1:0] kdiv_q, kdiv_d;

  logic key_step;
  logic shift_base;

  assign key_step = (kdiv_q == KDW'(KEY_DIV - 1));

  always_comb begin
    key_state_d = key_state_q;
    idx_d       = idx_q;
    cand_d      = cand_q;
    kbcode_d    = kbcode_q;
    shift_d     = shift_q;
    irq_d       = 1'b0;
    shift_base  = shift_q;
    kdiv_d      = key_step ? '0 : kdiv_q + KDW'(1);

    if (key_step) begin
      idx_d = idx_q + 6'd1;

      // A new pass starts at index 0, so the modifier seen in the previous
      // pass is dropped there; the current step's modifier still counts.
      shift_base = (idx_q == 6'd0) ? 1'b0 : shift_q;
      shift_d    = shift_base | ~kr2_L;

      unique case (key_state_q)
        K_IDLE: begin
          if (!kr1_L) begin
            cand_d      = idx_q;
            key_state_d = K_CHECK;
          end
        end
        K_CHECK: begin
          // Debounce: the key must still be down one full pass later
          if (idx_q == cand_q) begin
            if (!kr1_L) begin
              kbcode_d    = {1'b0, shift_d, cand_q};
              irq_d       = 1'b1;
              key_state_d = K_HELD;
            end else begin
              key_state_d = K_IDLE;
            end
          end
        end
        K_HELD: begin
          if (idx_q == cand_q && kr1_L) begin
            key_state_d = K_IDLE;
          end
        end
        default: key_state_d = K_IDLE;
      endcase
    end
  end

  always_ff @(posedge o2) begin
    if (rst) begin
      key_state_q <= K_IDLE;
      idx_q       <= 6'd0;
      cand_q      <= 6'd0;
      kbcode_q    <= 8'd0;
      shift_q     <= 1'b0;
      irq_q       <= 1'b0;
      kdiv_q      <= '0;
    end else begin
      key_state_q <= key_state_d;
      idx_q       <= idx_d;
      cand_q      <= cand_d;
      kbcode_q    <= kbcode_d;
      shift_q     <= shift_d;
      irq_q       <= irq_d;
      kdiv_q      <= kdiv_d;
    end
  end

  assign key_scan_L = ~idx_q;
  assign kbd_irq    = irq_q;

  // --------------------------------------------------------------- readback
  logic [7:0] allpot;
  logic [7:0] pot_rd [8];
  logic [7:0] skstat;

  always_comb begin
    allpot = 8'd0;
    if (pot_state_q == SCAN) begin
      allpot[NUM_POTS-1:0] = ~latch_q;
    end
    for (int i = 0; i < 8; i++) begin
      pot_rd[i] = 8'd0;
    end
    for (int i = 0; i < NUM_POTS; i++) begin
      pot_rd[i] = pot_q[i];
    end
  end

  assign skstat = {5'b11111, ~(key_state_q == K_HELD), 2'b11};

  always_comb begin
    data_out = 8'h00;
    case (addr_bus)
      4'h0, 4'h1, 4'h2, 4'h3,
      4'h4, 4'h5, 4'h6, 4'h7: data_out = pot_rd[addr_bus[2:0]];
      4'h8:                   data_out = allpot;
      4'h9:                   data_out = kbcode_q;
      4'hF:                   data_out = skstat;
      default:                data_out = 8'h00;
    endcase
  end

endmodule
